// File: rtl/mem_access_unit_if.sv
// Request/response and RAM bus bundle for the load/store sequencer.
// The slave modport is the sequencer; the master modport is everything around it
// (the CPU request side plus the RAM).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer between the CPU datapath and a word-addressed RAM.
// One request at a time; every access is bounded by a wait-cycle timeout.
// All outputs are registered and updated together with the state.
module mem_access_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                  CLK,
    input  logic                  reset,
    mem_access_unit_if.slave      bus,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    state_e     state_q;
    logic [7:0] wait_cnt_q;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= StIdle;
            wait_cnt_q    <= 8'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= DATA_W'(0);
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bus.rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        bus.mem_we    <= bus.req_we;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_wdata <= bus.req_wdata;
                        wait_cnt_q    <= 8'd0;
                        bus.mem_en    <= 1'b1;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        state_q       <= StAccess;
                    end
                end
                StAccess: begin
                    // An acknowledge on the timeout edge still completes normally.
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) begin
                            bus.rsp_rdata <= bus.mem_rdata;
                        end
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.mem_en    <= 1'b0;
                        state_q       <= StResp;
                    end else if (wait_cnt_q == WaitLast) begin
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.mem_en    <= 1'b0;
                        state_q       <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    busy          <= 1'b0;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q       <= StIdle;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.mem_en    <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
